// File: rtl/lc3_wb_arbiter.sv
// lc3_wb_arbiter: writeback arbiter and register scoreboard for the LC-3 register file
// Ports: clk/rst; issue allocation (iss_valid, iss_dr, iss_sr1, iss_sr2, iss_use_sr2 -> iss_ready);
// requesters A/B (x_valid, x_dr, x_data -> x_ready); register file write port (rf_we, rf_dr, rf_d);
// status (busy, wb_err, wb_count).
// LC3_WB_FIXED_PRI_EN: when defined, B always wins a tie and the prio register is removed.
module lc3_wb_arbiter #(
  parameter int RLEN = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [2:0]      iss_dr,
  input  logic [2:0]      iss_sr1,
  input  logic [2:0]      iss_sr2,
  input  logic            iss_use_sr2,
  output logic            iss_ready,
  input  logic            a_valid,
  input  logic [2:0]      a_dr,
  input  logic [15:0]     a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [2:0]      b_dr,
  input  logic [15:0]     b_data,
  output logic            b_ready,
  output logic            rf_we,
  output logic [2:0]      rf_dr,
  output logic [15:0]     rf_d,
  output logic [RLEN-1:0] busy,
  output logic            wb_err,
  output logic [CW-1:0]   wb_count
);
  logic [RLEN-1:0] busy_q, busy_d, clr, eff_busy;
  logic wb_err_q, wb_err_d;
  logic [CW-1:0] wb_count_q, wb_count_d;
`ifndef LC3_WB_FIXED_PRI_EN
  logic prio_q, prio_d;
`endif
  always_comb begin
`ifdef LC3_WB_FIXED_PRI_EN
    a_ready = !rst && a_valid && !b_valid;
    b_ready = !rst && b_valid;
`else
    a_ready = !rst && a_valid && !(b_valid && prio_q);
    b_ready = !rst && b_valid && !(a_valid && !prio_q);
    prio_d = a_ready ? 1'b1 : b_ready ? 1'b0 : prio_q;
`endif
    rf_we = a_ready || b_ready;
    rf_dr = a_ready ? a_dr : b_ready ? b_dr : 3'd0;
    rf_d = a_ready ? a_data : b_ready ? b_data : 16'd0;
    clr = rf_we ? RLEN'(1) << rf_dr : '0;
    // the register file forwards same-cycle writes, so a register being written is not a hazard
    eff_busy = busy_q & ~clr;
    iss_ready = !rst && iss_valid && !eff_busy[iss_dr] && !eff_busy[iss_sr1] &&
                !(iss_use_sr2 && eff_busy[iss_sr2]);
    busy_d = eff_busy | (iss_ready ? RLEN'(1) << iss_dr : '0);
    wb_err_d = wb_err_q || (rf_we && !busy_q[rf_dr]);
    wb_count_d = wb_count_q + CW'(rf_we);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      wb_err_q <= 1'b0;
      wb_count_q <= '0;
`ifndef LC3_WB_FIXED_PRI_EN
      prio_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      wb_err_q <= wb_err_d;
      wb_count_q <= wb_count_d;
`ifndef LC3_WB_FIXED_PRI_EN
      prio_q <= prio_d;
`endif
    end
  end
  assign busy = busy_q;
  assign wb_err = wb_err_q;
  assign wb_count = wb_count_q;
endmodule

// File: tb/tb_lc3_wb_arbiter.sv
// tb_lc3_wb_arbiter: scoreboard bench for lc3_wb_arbiter
module tb_lc3_wb_arbiter;
  logic clk = 0, rst = 1;
  logic iss_valid = 0, iss_use_sr2 = 0;
  logic [2:0] iss_dr = 0, iss_sr1 = 0, iss_sr2 = 0;
  logic iss_ready;
  logic a_valid = 0, b_valid = 0;
  logic [2:0] a_dr = 0, b_dr = 0;
  logic [15:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, rf_we, wb_err;
  logic [2:0] rf_dr;
  logic [15:0] rf_d, wb_count;
  logic [7:0] busy;
  typedef struct packed {logic [2:0] dr; logic [15:0] d; logic src;} wb_t;
  wb_t q[$];
  wb_t e;
  int total = 0, bad = 0;

  lc3_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_dr(iss_dr), .iss_sr1(iss_sr1), .iss_sr2(iss_sr2),
    .iss_use_sr2(iss_use_sr2), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_dr(a_dr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dr(b_dr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_d(rf_d),
    .busy(busy), .wb_err(wb_err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_we) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got dr=%0d d=%h, expected no write", rf_dr, rf_d);
      end else begin
        e = q.pop_front();
        if (rf_dr !== e.dr || rf_d !== e.d || b_ready !== e.src || a_ready !== !e.src) begin
          bad++;
          $display("FAIL writeback got dr=%0d d=%h a=%b b=%b, expected dr=%0d d=%h src=%s",
                   rf_dr, rf_d, a_ready, b_ready, e.dr, e.d, e.src ? "B" : "A");
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] dr, input logic [15:0] d, input logic src);
    q.push_back({dr, d, src});
  endtask

  initial begin
    iss_valid = 1; a_valid = 1; b_valid = 1; a_dr = 1; b_dr = 2;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rf_we", 32'(rf_we), 0);
      chk("rst_iss_ready", 32'(iss_ready), 0);
      chk("rst_ready", {a_ready, b_ready}, 0);
      tick();
    end
    rst = 0; iss_valid = 0; a_valid = 0; b_valid = 0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(wb_count), 0);
    chk("rst_err", 32'(wb_err), 0);

    iss_valid = 1; iss_dr = 3; iss_sr1 = 0; iss_sr2 = 0;
    #1 chk("alloc_ready", 32'(iss_ready), 1);
    tick();
    iss_valid = 0;
    chk("alloc_busy", 32'(busy), 32'h08);
    a_valid = 1; a_dr = 3; a_data = 16'h1234; push(3, 16'h1234, 0);
    #1 chk("wb_rf_we", 32'(rf_we), 1);
    chk("wb_rf_dr", 32'(rf_dr), 3);
    chk("wb_rf_d", 32'(rf_d), 32'h1234);
    chk("wb_ready", {a_ready, b_ready}, 2);
    tick();
    a_valid = 0;
    chk("wb_busy", 32'(busy), 0);
    chk("wb_count1", 32'(wb_count), 1);
    #1 chk("idle_rf", {rf_we, rf_dr, rf_d}, 0);

    iss_valid = 1; iss_dr = 5;
    tick();
    iss_dr = 6; iss_sr1 = 5;
    #1 chk("raw_stall", 32'(iss_ready), 0);
    tick();
    chk("raw_busy", 32'(busy), 32'h20);
    b_valid = 1; b_dr = 5; b_data = 16'h5555; push(5, 16'h5555, 1);
    #1 chk("raw_bypass", 32'(iss_ready), 1);
    tick();
    iss_valid = 0; b_valid = 0; iss_sr1 = 0;
    chk("raw_busy2", 32'(busy), 32'h40);
    chk("raw_count", 32'(wb_count), 2);

    rst = 1;
    tick();
    rst = 0;
    chk("rst2_busy", 32'(busy), 0);
    iss_valid = 1; iss_dr = 1;
    tick();
    iss_dr = 2;
    tick();
    iss_valid = 0;
    chk("rr_busy0", 32'(busy), 32'h06);
    a_valid = 1; a_dr = 1; a_data = 16'h1111;
    b_valid = 1; b_dr = 2; b_data = 16'h2222;
`ifdef LC3_WB_FIXED_PRI_EN
    push(2, 16'h2222, 1); push(1, 16'h1111, 0);
    tick();
    b_valid = 0;
    chk("rr_busy1", 32'(busy), 32'h02);
    tick();
    a_valid = 0;
`else
    push(1, 16'h1111, 0); push(2, 16'h2222, 1);
    tick();
    a_valid = 0;
    chk("rr_busy1", 32'(busy), 32'h04);
    tick();
    b_valid = 0;
`endif
    chk("rr_busy2", 32'(busy), 0);

    a_valid = 1; a_dr = 7; a_data = 16'h7777; push(7, 16'h7777, 0);
    #1 chk("err_we", 32'(rf_we), 1);
    chk("err_pre", 32'(wb_err), 0);
    tick();
    a_valid = 0;
    chk("err_set", 32'(wb_err), 1);
    tick();
    tick();
    chk("err_sticky", 32'(wb_err), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("err_clear", 32'(wb_err), 0);
    chk("count_clear", 32'(wb_count), 0);

    a_valid = 1; a_dr = 0; a_data = 16'h0000;
    for (int i = 0; i < 65535; i++) begin
      push(0, 16'h0000, 0);
      tick();
    end
    chk("count_max", 32'(wb_count), 32'hFFFF);
    push(0, 16'h0000, 0);
    tick();
    a_valid = 0;
    chk("count_wrap", 32'(wb_count), 0);
    tick();
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lc3_wb_arbiter.md
# lc3_wb_arbiter

Writeback arbiter and register scoreboard for the LC-3 8×16 register file. Shares the file's single write port between two writeback requesters (A = ALU/execute, B = memory load) with valid/ready handshakes and round-robin priority. Tracks per-register pending-write busy bits so the issue stage can stall on RAW/WAW hazards. Drives the register file's `we`/`DR`/`d` inputs directly.

## Interface
Parameters:
- `RLEN`, 8: number of architectural registers; sets the scoreboard width.
- `CW`, 16: width of the writeback counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `iss_valid` in 1: issue stage requests allocation of `iss_dr`.
- `iss_dr` in 3: destination register to allocate.
- `iss_sr1`, `iss_sr2` in 3: source registers of the issuing instruction.
- `iss_use_sr2` in 1: `iss_sr2` is read (0 = immediate form).
- `iss_ready` out 1: allocation accepted this cycle.
- `a_valid` in 1, `a_dr` in 3, `a_data` in 16, `a_ready` out 1: requester A writeback.
- `b_valid` in 1, `b_dr` in 3, `b_data` in 16, `b_ready` out 1: requester B writeback.
- `rf_we` out 1, `rf_dr` out 3, `rf_d` out 16: to register file write port.
- `busy` out RLEN: scoreboard state (registered).
- `wb_err` out 1: sticky; a writeback targeted a non-busy register.
- `wb_count` out CW: count of completed writebacks.

## Operation
- **Grant:** combinational from `a_valid`, `b_valid` and `prio`.
  - Only one valid: that requester wins.
  - Both valid: `prio`=0 → A wins, `prio`=1 → B wins.
  - `a_ready`/`b_ready` equal the grant; at most one is high.
  - `rf_we` = `a_ready | b_ready`. `rf_dr`/`rf_d` are muxed from the winner.
  - When `rf_we`=0, `rf_dr`/`rf_d` are 0.
- **Priority:** `prio` is a register.
  - A granted → `prio`=1.
  - B granted → `prio`=0.
  - No grant → unchanged.
- **Requester rule:** once `x_valid` is high, it must stay high with stable `x_dr`/`x_data` until `x_ready`. The arbiter does not buffer.
- **Clear set:** `clr` = register being written this cycle (`rf_dr` when `rf_we`).
- **Hazard:** `eff_busy` = `busy` with the `clr` bit removed. This is valid because the register file forwards `d` on a same-cycle read.
  - `iss_ready` = `iss_valid & !eff_busy[iss_dr] & !eff_busy[iss_sr1] & !(iss_use_sr2 & eff_busy[iss_sr2])`.
- **Scoreboard update:**
  - `busy[i]` next = (`busy[i]` & !`clr[i]`) | (`iss_ready` & `iss_dr`==i).
  - Set wins over clear for the same register in the same cycle.
- **Error:** `wb_err` is set when `rf_we` and `!busy[rf_dr]`. The write still proceeds. `wb_err` holds until reset.
- **Counter:** `wb_count` increments by 1 per cycle with `rf_we`=1 and wraps from all-ones to 0.

## Timing
- Grant, ready, `rf_*` and `iss_ready` are combinational: 0-cycle latency from request to write strobe. The register file commits at the same rising edge.
- `busy`, `prio`, `wb_err`, `wb_count` update at the rising edge after the event.
- **Reset** (sync, has priority over all updates):
  - `busy`=0, `prio`=0, `wb_err`=0, `wb_count`=0.
  - While `rst` is high, `iss_ready`, `a_ready`, `b_ready` and `rf_we` are forced to 0.
  - Reset mid-transaction discards pending allocations; requesters must re-present after reset.
- **Same-register collision:** A and B both target the same register in the same cycle. Only the winner writes; the loser writes the following cycle. Its write clears an already-cleared bit and raises `wb_err`. Avoiding this is the issue stage's responsibility.
- **Re-allocation on writeback:** issue may allocate register r in the cycle r is written back. `busy[r]` stays 1.

## Configuration
- `LC3_WB_FIXED_PRI_EN`:
  - Defined: B (memory) always wins when both are valid. The `prio` register is removed. A can starve while B is continuously valid.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst` 2 cycles with all inputs valid → `busy`=0x00, `wb_count`=0, `wb_err`=0, `rf_we`=0 throughout.
- **Allocate then write back:** issue allocates R3 (`iss_valid`=1, `iss_dr`=3) → `busy`=0x08 next cycle. A writes R3=0x1234 → `rf_we`=1, `rf_dr`=3, `rf_d`=0x1234, `a_ready`=1; `busy`=0x00 next cycle; `wb_count`=1.
- **RAW stall and bypass release:**
  - R5 busy, issue with `iss_sr1`=5 → `iss_ready`=0.
  - Same issue in the cycle B writes R5 → `iss_ready`=1.
- **Round-robin:** R1 and R2 busy; A (R1) and B (R2) both valid from the cycle after reset → A granted first, B granted second; `busy` goes 0x06 → 0x04 → 0x00. Under `LC3_WB_FIXED_PRI_EN`, B is granted first.
- **Error flag:** A writes R7 while `busy[7]`=0 → write occurs, `wb_err`=1 from the next cycle and stays 1 until `rst`.
- **Counter wrap:** preload via 65535 writebacks, then one more → `wb_count` goes 0xFFFF → 0x0000.
